// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin front end for a shared combinational ALU.
// One operation in flight at a time. Multiply holds EXEC for MUL_WAIT extra cycles.
// Illegal opcodes get an error response.
module alu_sched #(
    parameter int unsigned MUL_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] OP_MUL = 4'b0110;

    logic [1:0]  state;
    logic        prio;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        id_q;
    logic [3:0]  cnt;
    logic        grant0;
    logic        grant1;
    logic        op_legal;
    logic [3:0]  next_op;

    // Round-robin arbitration and handshake; readies only in IDLE and never during reset
    always_comb begin
        grant0     = req0_valid && (!req1_valid || !prio);
        grant1     = req1_valid && (!req0_valid ||  prio);
        req0_ready = (state == S_IDLE) && !rst && grant0;
        req1_ready = (state == S_IDLE) && !rst && grant1;
        next_op    = grant1 ? req1_op : req0_op;
    end

    // Decode legality of the latched opcode
    always_comb begin
        case (op_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0101, 4'b0110, 4'b0111: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    // ALU drive comes only from latched operands; status outputs decode the state
    always_comb begin
        alu_in1     = a_q;
        alu_in2     = b_q;
        alu_control = op_q;
        rsp_valid   = (state == S_RESP);
        busy        = (state != S_IDLE);
    end

    // Scheduler FSM: grant/latch, timed EXEC, hold response until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prio       <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            cnt        <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_q  <= next_op;
                        a_q   <= req1_ready ? req1_a : req0_a;
                        b_q   <= req1_ready ? req1_b : req0_b;
                        id_q  <= req1_ready;
                        prio  <= req0_ready;
                        cnt   <= (next_op == OP_MUL) ? 4'(MUL_WAIT) : 4'd0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!op_legal) begin
                        rsp_id     <= id_q;
                        rsp_result <= '0;
                        rsp_zero   <= 1'b1;
                        rsp_err    <= 1'b1;
                        state      <= S_RESP;
                    end else if (cnt == 4'd0) begin
                        rsp_id     <= id_q;
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: table of directed operations plus
// hand sequences for response back-pressure and reset during multiply.
module tb_alu_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_in1, alu_in2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_err, busy;

    int total = 0;
    int bad   = 0;

    alu_sched #(.MUL_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference combinational ALU; illegal codes return a marker the DUT must ignore
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_in1 & alu_in2;
            4'b0001: alu_result = alu_in1 | alu_in2;
            4'b0010: alu_result = alu_in1 + alu_in2;
            4'b0100: alu_result = alu_in1 - alu_in2;
            4'b1000: alu_result = {31'b0, ($signed(alu_in1) < $signed(alu_in2))};
            4'b0011: alu_result = alu_in1 ^ alu_in2;
            4'b0101: alu_result = ~(alu_in1 | alu_in2);
            4'b0110: alu_result = alu_in1 * alu_in2;
            4'b0111: alu_result = alu_in1 << alu_in2[4:0];
            default: alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic        v0;
        logic        v1;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_id;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic v0, input logic v1, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        req0_valid = v0;
        req1_valid = v1;
        req0_op = op;
        req1_op = op;
        req0_a = a;
        req1_a = a;
        req0_b = b;
        req1_b = b;
    endtask

    task automatic run_vec(input vec_t v);
        bit   granted;
        logic got_id;
        int   lat;
        granted = 1'b0;
        got_id  = 1'b0;
        lat     = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(v.v0, v.v1, v.op, v.a, v.b);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                granted = 1'b1;
                got_id  = req1_ready;
                chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
                break;
            end
            @(negedge clk);
        end
        chk("grant_seen", 32'(granted), 32'd1);
        if (!granted) return;
        chk("grant_id", 32'(got_id), 32'(v.exp_id));
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req0_op = 4'b1010; req1_op = 4'b1011;
                req0_a = 32'hBAD0BAD0; req1_a = 32'hBAD1BAD1;
                req0_b = 32'h0000BAD0; req1_b = 32'h0000BAD1;
            end
            #1;
            if (c == 1) begin
                chk("exec_in1", alu_in1, v.a);
                chk("exec_in2", alu_in2, v.b);
                chk("exec_ctl", 32'(alu_control), 32'(v.op));
                chk("exec_noready", 32'({req0_ready, req1_ready}), 32'd0);
            end
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(v.exp_lat));
        if (lat == 0) return;
        chk("rsp_id", 32'(rsp_id), 32'(v.exp_id));
        chk("rsp_result", rsp_result, v.exp_res);
        chk("rsp_zero", 32'(rsp_zero), 32'(v.exp_zero));
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_idle", 32'(busy), 32'd0);
        chk("accept_novalid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stray;
        vec_t post;
        //          v0    v1    op       a             b             id    result        zero  err   lat
        vecs[0]  = '{1'b1, 1'b0, 4'b0010, 32'd5,        32'd7,        1'b0, 32'd12,       1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 1'b1, 4'b0110, 32'd65536,    32'd65536,    1'b1, 32'd0,        1'b1, 1'b0, 4};
        vecs[2]  = '{1'b1, 1'b1, 4'b0100, 32'd3,        32'd3,        1'b0, 32'd0,        1'b1, 1'b0, 2};
        vecs[3]  = '{1'b1, 1'b1, 4'b0100, 32'd3,        32'd3,        1'b1, 32'd0,        1'b1, 1'b0, 2};
        vecs[4]  = '{1'b1, 1'b1, 4'b0100, 32'd3,        32'd3,        1'b0, 32'd0,        1'b1, 1'b0, 2};
        vecs[5]  = '{1'b1, 1'b1, 4'b0100, 32'd3,        32'd3,        1'b1, 32'd0,        1'b1, 1'b0, 2};
        vecs[6]  = '{1'b1, 1'b0, 4'b1111, 32'd4,        32'd4,        1'b0, 32'd0,        1'b1, 1'b1, 2};
        vecs[7]  = '{1'b0, 1'b1, 4'b0001, 32'h000000F0, 32'h0000000F, 1'b1, 32'h000000FF, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b1, 1'b1, 4'b0000, 32'h000000F0, 32'h0000000F, 1'b0, 32'd0,        1'b1, 1'b0, 2};
        vecs[9]  = '{1'b1, 1'b1, 4'b0011, 32'd5,        32'd5,        1'b1, 32'd0,        1'b1, 1'b0, 2};
        vecs[10] = '{1'b0, 1'b1, 4'b0111, 32'd1,        32'd4,        1'b1, 32'd16,       1'b0, 1'b0, 2};
        vecs[11] = '{1'b1, 1'b0, 4'b0101, 32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 2};
        vecs[12] = '{1'b1, 1'b0, 4'b1001, 32'd1,        32'd1,        1'b0, 32'd0,        1'b1, 1'b1, 2};
        vecs[13] = '{1'b1, 1'b1, 4'b0110, 32'd3,        32'd7,        1'b1, 32'd21,       1'b0, 1'b0, 4};

        rst = 1'b1;
        rsp_ready = 1'b0;
        drive_req(1'b1, 1'b0, 4'b0010, 32'd1, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_ctl", 32'(alu_control), 32'd0);
        chk("rst_rsp", {rsp_result[28:0], rsp_id, rsp_zero, rsp_err}, 32'd0);
        drive_req(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response back-pressure: op 1000 2<9 held for five cycles, no new grant meanwhile
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(1'b1, 1'b0, 4'b1000, 32'd2, 32'd9);
        #1;
        chk("hold_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_result", rsp_result, 32'd1);
            chk("hold_noready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", 32'(busy), 32'd0);

        // Reset during multiply EXEC: requester 0 granted so prio would point to 1
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(1'b1, 1'b0, 4'b0110, 32'd65536, 32'd3);
        #1;
        chk("mrst_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        req1_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_alu_in1", alu_in1, 32'd0);
        chk("mrst_alu_in2", alu_in2, 32'd0);
        chk("mrst_alu_ctl", 32'(alu_control), 32'd0);
        chk("mrst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req1_valid = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) stray++;
        end
        chk("mrst_no_rsp", 32'(stray), 32'd0);
        post = '{1'b1, 1'b1, 4'b0010, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 2};
        run_vec(post);

        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
